// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD to Excess-3 sequencing controller.
//   state_e     : controller FSM states
//   BCD_MAX     : largest legal BCD digit value
//   EXC3_OFFSET : Excess-3 bias added to each legal digit
//   ERR_DIGIT   : field value written in place of an illegal digit
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] EXC3_OFFSET = 4'd3;
  localparam logic [3:0] ERR_DIGIT   = 4'b0000;

endpackage

// File: rtl/bcd_exc3_digit.sv
// Combinational single-digit BCD to Excess-3 converter.
//   bcd     : input BCD digit
//   exc     : Excess-3 code, or ERR_DIGIT when the input is not legal BCD
//   invalid : high when the input digit is greater than BCD_MAX
module bcd_exc3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [3:0] exc,
  output logic       invalid
);

  always_comb begin
    invalid = (bcd > BCD_MAX);
    exc     = invalid ? ERR_DIGIT : (bcd + EXC3_OFFSET);
  end

endmodule

// File: rtl/bcd_exc3_seq_ctrl.sv
// Sequencing controller: converts a packed NDIGITS-digit BCD word to Excess-3
// through one shared digit converter, least-significant digit first, one
// digit per clock.
//   clk, rst_n               : clock, synchronous active-low reset
//   in_valid/in_ready/in_bcd : input word handshake
//   out_valid/out_ready      : output result handshake
//   out_exc                  : packed Excess-3 result
//   out_err_mask / out_err   : per-digit illegal-BCD flags and their OR
//   busy                     : high whenever the controller is not idle
module bcd_exc3_seq_ctrl
  import bcd_pkg::*;
#(
  parameter  int unsigned NDIGITS = 4,
  localparam int unsigned DW      = 4 * NDIGITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_bcd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_exc,
  output logic               out_err,
  output logic [NDIGITS-1:0] out_err_mask,
  output logic               busy
);

  localparam int unsigned       IW       = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0]     IDX_LAST = IW'(NDIGITS - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DW-1:0]        word_q, word_d;
  logic [DW-1:0]        exc_q, exc_d;
  logic [NDIGITS-1:0]   mask_q, mask_d;

  logic [3:0]           dig_bcd;
  logic [3:0]           dig_exc;
  logic                 dig_inv;

  // The single shared converter always sees the digit selected by idx_q.
  assign dig_bcd = word_q[{idx_q, 2'b00} +: 4];

  bcd_exc3_digit u_digit (
    .bcd     (dig_bcd),
    .exc     (dig_exc),
    .invalid (dig_inv)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    exc_d   = exc_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_bcd;
          exc_d   = '0;
          mask_d  = '0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        exc_d[{idx_q, 2'b00} +: 4] = dig_exc;
        mask_d[idx_q]              = dig_inv;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      exc_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      exc_q   <= exc_d;
      mask_q  <= mask_d;
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_exc      = exc_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;

endmodule

// File: tb/tb_bcd_exc3_seq_ctrl.sv
// Self-checking bench for bcd_exc3_seq_ctrl with NDIGITS=4.
module tb_bcd_exc3_seq_ctrl;

  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_bcd;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_exc;
  logic          out_err;
  logic [3:0]    out_err_mask;
  logic          busy;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  int unsigned   cyc_cnt  = 0;
  int unsigned   last_accept = 0;

  bcd_exc3_seq_ctrl #(.NDIGITS(ND)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bcd       (in_bcd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_exc      (out_exc),
    .out_err      (out_err),
    .out_err_mask (out_err_mask),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: digit-wise arithmetic on the integer value of the word.
  function automatic void ref_conv(input logic [15:0] w, output logic [15:0] e,
                                   output logic [3:0] m);
    int unsigned d;
    int unsigned acc;
    acc = 0;
    m   = '0;
    for (int k = 0; k < 4; k++) begin
      d = (int'(w) / (16 ** k)) % 16;
      if (d <= 9) acc = acc + (d + 3) * (16 ** k);
      else        m[k] = 1'b1;
    end
    e = acc[15:0];
  endfunction

  // Send one word, wait for its result, hold out_ready low for bp cycles,
  // then complete the output handshake. Called and returns at posedge+#1.
  task automatic xfer(input logic [15:0] w, input logic [15:0] exp_e,
                      input logic [3:0] exp_m, input int bp);
    int cyc;
    in_valid  = 1'b1;
    in_bcd    = w;
    out_ready = (bp == 0);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("accept_timeout", 32'(cyc < 50), 1);
    @(posedge clk);
    last_accept = cyc_cnt;
    #1;
    // Keep valid asserted with junk data: must be ignored outside IDLE.
    in_bcd = 16'($urandom);
    chk("in_ready_conv", 32'(in_ready), 0);
    chk("busy_conv", 32'(busy), 1);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(cyc), ND);
    chk("out_exc", 32'(out_exc), 32'(exp_e));
    chk("out_err_mask", 32'(out_err_mask), 32'(exp_m));
    chk("out_err", 32'(out_err), 32'(|exp_m));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_exc", 32'(out_exc), 32'(exp_e));
      chk("bp_mask", 32'(out_err_mask), 32'(exp_m));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_valid", 32'(out_valid), 0);
    chk("post_in_ready", 32'(in_ready), 1);
    chk("post_busy", 32'(busy), 0);
    chk("post_hold_exc", 32'(out_exc), 32'(exp_e));
  endtask

  initial begin
    logic [15:0] w, e;
    logic [3:0]  m;
    int unsigned a0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = 16'hFFFF;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_exc", 32'(out_exc), 0);
    chk("rst_mask", 32'(out_err_mask), 0);
    chk("rst_err", 32'(out_err), 0);
    rst_n = 1'b1;

    // Directed words with hand-computed expectations.
    xfer(16'h1234, 16'h4567, 4'b0000, 0);
    xfer(16'h9870, 16'hCBA3, 4'b0000, 0);
    xfer(16'h12A4, 16'h4507, 4'b0010, 0);
    xfer(16'hFFFF, 16'h0000, 4'b1111, 0);
    xfer(16'h0042, 16'h3375, 4'b0000, 6);

    // Reset in the middle of conversion discards the word.
    in_valid = 1'b1;
    in_bcd   = 16'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_exc", 32'(out_exc), 0);
    chk("midrst_mask", 32'(out_err_mask), 0);
    chk("midrst_busy", 32'(busy), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_result", 32'(out_valid), 0);
    xfer(16'h0005, 16'h3338, 4'b0000, 0);

    // Back-to-back: accept spacing must be NDIGITS+2 cycles.
    xfer(16'h0000, 16'h3333, 4'b0000, 0);
    a0 = last_accept;
    xfer(16'h9999, 16'hCCCC, 4'b0000, 0);
    chk("b2b_spacing", 32'(last_accept - a0), ND + 2);

    // Randomized words: each digit illegal with about 1/4 probability.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(3) == 0) w[4*k +: 4] = 4'($urandom_range(15, 10));
        else                        w[4*k +: 4] = 4'($urandom_range(9, 0));
      end
      ref_conv(w, e, m);
      xfer(w, e, m, int'($urandom_range(3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
